// File: rtl/ifft3_stream_if.sv
// Valid/ready stream bundle for the radix-3 inverse butterfly: frequency-domain
// samples in, time-domain samples out. The slave side is the butterfly itself.
interface ifft3_stream_if #(
  parameter int W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_re;
  logic signed [W-1:0]   in_img;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W+1:0]   out_re;
  logic signed [W+1:0]   out_img;
  logic                  out_last;

  modport slave (
    input  in_valid,
    input  in_re,
    input  in_img,
    output in_ready,
    output out_valid,
    output out_re,
    output out_img,
    output out_last,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_re,
    output in_img,
    input  in_ready,
    input  out_valid,
    input  out_re,
    input  out_img,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ifft3_stream.sv
// Streaming 3-point inverse DFT: collects X0..X2, emits unscaled x0..x2 serially.
// Define IFFT3_ROUND_EN to round the sqrt(3)/2 products half-up instead of flooring them.
module ifft3_stream #(
  parameter int          W         = 16,
  parameter int unsigned C_SQRT3_2 = 28378
) (
  input logic           clk,
  input logic           rst_n,
  ifft3_stream_if.slave bus
);

  localparam int OW = W + 2;
  localparam int PW = W + 17;

`ifdef IFFT3_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(16384);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  // Stage A: collector
  logic signed [W-1:0]  a_re_reg [3];
  logic signed [W-1:0]  a_im_reg [3];
  logic [1:0]           a_idx_reg, a_idx_next;
  logic                 a_full_reg, a_full_next;
  logic [2:0]           a_we;

  // Stage B: result buffer
  logic signed [OW-1:0] b_re_reg [3];
  logic signed [OW-1:0] b_im_reg [3];
  logic                 b_full_reg, b_full_next;
  logic [1:0]           out_cnt_reg, out_cnt_next;

  // Handshake and transfer control
  logic                 in_ready_int;
  logic                 in_fire;
  logic                 out_fire;
  logic                 out_wrap;
  logic                 transfer;

  // Butterfly datapath
  logic signed [W:0]    s_re, s_im, d_re, d_im, h_re, h_im;
  logic signed [PW-1:0] c_ext, m_re, m_im;
  logic signed [OW-1:0] p_re, p_im, t_re, t_im;
  logic signed [OW-1:0] r_re [3];
  logic signed [OW-1:0] r_im [3];

  assign out_fire     = b_full_reg && bus.out_ready;
  assign out_wrap     = out_fire && (out_cnt_reg == 2'd2);
  // B can take a new frame when empty or when its last sample leaves this cycle.
  assign transfer     = a_full_reg && (!b_full_reg || out_wrap);
  assign in_ready_int = !a_full_reg || transfer;
  assign in_fire      = bus.in_valid && in_ready_int;
  assign bus.in_ready = in_ready_int;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_a_we
      assign a_we[gi] = in_fire && (a_idx_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        a_re_reg[i] <= '0;
        a_im_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (a_we[i]) begin
          a_re_reg[i] <= bus.in_re;
          a_im_reg[i] <= bus.in_img;
        end
      end
    end
  end

  assign c_ext = PW'(C_SQRT3_2);

  always_comb begin
    s_re = (W+1)'(a_re_reg[1]) + (W+1)'(a_re_reg[2]);
    s_im = (W+1)'(a_im_reg[1]) + (W+1)'(a_im_reg[2]);
    d_re = (W+1)'(a_re_reg[1]) - (W+1)'(a_re_reg[2]);
    d_im = (W+1)'(a_im_reg[1]) - (W+1)'(a_im_reg[2]);
    h_re = s_re >>> 1;
    h_im = s_im >>> 1;
    m_re = PW'(d_re) * c_ext;
    m_im = PW'(d_im) * c_ext;
    p_re = OW'((m_re + RND) >>> 15);
    p_im = OW'((m_im + RND) >>> 15);
    // X0 - S/2 is common to x1 and x2; only the sign of the rotated difference differs.
    t_re = OW'(a_re_reg[0]) - OW'(h_re);
    t_im = OW'(a_im_reg[0]) - OW'(h_im);
    r_re[0] = OW'(a_re_reg[0]) + OW'(s_re);
    r_im[0] = OW'(a_im_reg[0]) + OW'(s_im);
    r_re[1] = t_re - p_im;
    r_im[1] = t_im + p_re;
    r_re[2] = t_re + p_im;
    r_im[2] = t_im - p_re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        b_re_reg[i] <= '0;
        b_im_reg[i] <= '0;
      end
    end else if (transfer) begin
      for (int i = 0; i < 3; i++) begin
        b_re_reg[i] <= r_re[i];
        b_im_reg[i] <= r_im[i];
      end
    end
  end

  always_comb begin
    a_idx_next   = a_idx_reg;
    a_full_next  = a_full_reg;
    b_full_next  = b_full_reg;
    out_cnt_next = out_cnt_reg;
    if (transfer) begin
      a_full_next = 1'b0;
    end
    if (in_fire) begin
      if (a_idx_reg == 2'd2) begin
        a_idx_next  = 2'd0;
        a_full_next = 1'b1;
      end else begin
        a_idx_next = a_idx_reg + 2'd1;
      end
    end
    if (out_fire) begin
      out_cnt_next = out_wrap ? 2'd0 : out_cnt_reg + 2'd1;
    end
    if (out_wrap) begin
      b_full_next = 1'b0;
    end
    if (transfer) begin
      b_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_idx_reg   <= 2'd0;
      a_full_reg  <= 1'b0;
      b_full_reg  <= 1'b0;
      out_cnt_reg <= 2'd0;
    end else begin
      a_idx_reg   <= a_idx_next;
      a_full_reg  <= a_full_next;
      b_full_reg  <= b_full_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

  always_comb begin
    bus.out_re  = b_re_reg[2];
    bus.out_img = b_im_reg[2];
    case (out_cnt_reg)
      2'd0: begin
        bus.out_re  = b_re_reg[0];
        bus.out_img = b_im_reg[0];
      end
      2'd1: begin
        bus.out_re  = b_re_reg[1];
        bus.out_img = b_im_reg[1];
      end
      default: begin
        bus.out_re  = b_re_reg[2];
        bus.out_img = b_im_reg[2];
      end
    endcase
  end

  assign bus.out_valid = b_full_reg;
  assign bus.out_last  = b_full_reg && (out_cnt_reg == 2'd2);

endmodule
